// File: rtl/acc_stack_unit.sv
// Accumulator for the SAP datapath: bus load modes, shift/rotate/increment ops,
// a carry flag and a small LIFO that saves and restores the accumulator value.
module acc_stack_unit #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] bus,
    output logic [WIDTH-1:0] aout,
    output logic             carry,
    output logic             zero,
    output logic             neg,
    output logic             stack_full,
    output logic             stack_empty,
    output logic             err_ovf,
    output logic             err_unf
);

    localparam int HALF  = WIDTH / 2;
    localparam int PTR_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);

    typedef enum logic [3:0] {
        OP_NOP        = 4'd0,
        OP_LOAD       = 4'd1,
        OP_LOAD_LO    = 4'd2,
        OP_LOAD_LO_SX = 4'd3,
        OP_LOAD_HI    = 4'd4,
        OP_SHL        = 4'd5,
        OP_SHR        = 4'd6,
        OP_ROL        = 4'd7,
        OP_INC        = 4'd8,
        OP_DEC        = 4'd9,
        OP_PUSH       = 4'd10,
        OP_POP        = 4'd11,
        OP_CLR        = 4'd12,
        OP_CLR_ERR    = 4'd13
    } op_e;

    logic [WIDTH-1:0] stack_mem [DEPTH];
    logic [PTR_W-1:0] count_q, count_next;
    logic [WIDTH-1:0] aout_q, aout_next;
    logic             carry_q, carry_next;
    logic             ovf_q, ovf_next;
    logic             unf_q, unf_next;
    logic             push_en;
    logic [IDX_W-1:0] push_idx;
    logic [IDX_W-1:0] pop_idx;
    logic [WIDTH:0]   inc_sum;
    logic [PTR_W-1:0] count_dec;

    assign push_idx  = count_q[IDX_W-1:0];
    assign count_dec = count_q - PTR_W'(1);
    assign pop_idx   = count_dec[IDX_W-1:0];
    assign inc_sum   = {1'b0, aout_q} + (WIDTH+1)'(1);

    always_comb begin
        aout_next  = aout_q;
        carry_next = carry_q;
        count_next = count_q;
        ovf_next   = ovf_q;
        unf_next   = unf_q;
        push_en    = 1'b0;
        if (op_valid) begin
            case (op)
                OP_LOAD:       aout_next = bus;
                OP_LOAD_LO:    aout_next = {{HALF{1'b0}}, bus[HALF-1:0]};
                OP_LOAD_LO_SX: aout_next = {{HALF{bus[HALF-1]}}, bus[HALF-1:0]};
                OP_LOAD_HI:    aout_next = {bus[HALF-1:0], aout_q[HALF-1:0]};
                OP_SHL: begin
                    carry_next = aout_q[WIDTH-1];
                    aout_next  = {aout_q[WIDTH-2:0], 1'b0};
                end
                OP_SHR: begin
                    carry_next = aout_q[0];
                    aout_next  = {1'b0, aout_q[WIDTH-1:1]};
                end
                // Rotate through carry: old carry enters at bit 0, MSB leaves into carry
                OP_ROL: {carry_next, aout_next} = {aout_q, carry_q};
                OP_INC: {carry_next, aout_next} = inc_sum;
                OP_DEC: begin
                    carry_next = (aout_q == '0);
                    aout_next  = aout_q - WIDTH'(1);
                end
                OP_PUSH: begin
                    if (count_q < DEPTH_P) begin
                        push_en    = 1'b1;
                        count_next = count_q + PTR_W'(1);
                    end else begin
                        ovf_next = 1'b1;
                    end
                end
                OP_POP: begin
                    if (count_q != '0) begin
                        aout_next  = stack_mem[pop_idx];
                        count_next = count_dec;
                    end else begin
                        unf_next = 1'b1;
                    end
                end
                OP_CLR:     aout_next = '0;
                OP_CLR_ERR: begin
                    ovf_next = 1'b0;
                    unf_next = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            aout_q  <= '0;
            carry_q <= 1'b0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            aout_q  <= aout_next;
            carry_q <= carry_next;
            count_q <= count_next;
            ovf_q   <= ovf_next;
            unf_q   <= unf_next;
        end
    end

    // Stack storage carries no reset; only entries below count are ever read
    always_ff @(posedge clk) begin
        if (push_en && !rst) begin
            stack_mem[push_idx] <= aout_q;
        end
    end

    assign aout        = aout_q;
    assign carry       = carry_q;
    assign zero        = (aout_q == '0);
    assign neg         = aout_q[WIDTH-1];
    assign stack_full  = (count_q == DEPTH_P);
    assign stack_empty = (count_q == '0);
    assign err_ovf     = ovf_q;
    assign err_unf     = unf_q;

endmodule

// File: tb/tb_acc_stack_unit.sv
// Directed bench for acc_stack_unit (WIDTH=16, DEPTH=4): hand-computed vectors
// checked with immediate assertions one cycle after each command.
module tb_acc_stack_unit;

    logic        clk;
    logic        rst;
    logic        op_valid;
    logic [3:0]  op;
    logic [15:0] bus;
    logic [15:0] aout;
    logic        carry, zero, neg, stack_full, stack_empty, err_ovf, err_unf;

    int vectors;
    int miscompares;

    acc_stack_unit #(.WIDTH(16), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .bus(bus),
        .aout(aout), .carry(carry), .zero(zero), .neg(neg),
        .stack_full(stack_full), .stack_empty(stack_empty),
        .err_ovf(err_ovf), .err_unf(err_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One command per cycle; outputs sampled 1 time unit after the capturing edge
    task automatic applyStimulus(input logic v, input logic [3:0] o, input logic [15:0] b);
        @(negedge clk);
        op_valid = v;
        op       = o;
        bus      = b;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
    endtask

    task automatic applyReset(input logic [3:0] o, input logic [15:0] b);
        @(negedge clk);
        rst      = 1'b1;
        op_valid = 1'b1;
        op       = o;
        bus      = b;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        op_valid = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b0;
        op_valid = 1'b0;
        op = 4'd0;
        bus = 16'h0;

        // Reset with a concurrent LOAD: reset wins
        applyReset(4'd1, 16'h1234);
        checkOutput("rst_aout",  aout, 16'h0000);
        checkOutput("rst_carry", {15'b0, carry}, 16'h0);
        checkOutput("rst_zero",  {15'b0, zero}, 16'h1);
        checkOutput("rst_empty", {15'b0, stack_empty}, 16'h1);
        checkOutput("rst_full",  {15'b0, stack_full}, 16'h0);
        checkOutput("rst_errs",  {14'b0, err_ovf, err_unf}, 16'h0);

        // Load modes
        applyStimulus(1'b1, 4'd1, 16'hA5C3);
        checkOutput("load",      aout, 16'hA5C3);
        checkOutput("load_zero", {15'b0, zero}, 16'h0);
        checkOutput("load_neg",  {15'b0, neg}, 16'h1);
        applyStimulus(1'b1, 4'd2, 16'h12F0);
        checkOutput("load_lo", aout, 16'h00F0);
        applyStimulus(1'b1, 4'd3, 16'h0080);
        checkOutput("load_lo_sx", aout, 16'hFF80);
        applyStimulus(1'b1, 4'd2, 16'h00F0);
        applyStimulus(1'b1, 4'd4, 16'h3412);
        checkOutput("load_hi", aout, 16'h12F0);
        applyReset(4'd1, 16'hBEEF);
        checkOutput("rst_over_load", aout, 16'h0000);

        // Shift / rotate / arithmetic
        applyStimulus(1'b1, 4'd1, 16'h8001);
        applyStimulus(1'b1, 4'd5, 16'h0);
        checkOutput("shl",       aout, 16'h0002);
        checkOutput("shl_carry", {15'b0, carry}, 16'h1);
        applyStimulus(1'b1, 4'd7, 16'h0);
        checkOutput("rol",       aout, 16'h0005);
        checkOutput("rol_carry", {15'b0, carry}, 16'h0);
        applyStimulus(1'b1, 4'd1, 16'hFFFF);
        applyStimulus(1'b1, 4'd8, 16'h0);
        checkOutput("inc",       aout, 16'h0000);
        checkOutput("inc_zero",  {15'b0, zero}, 16'h1);
        checkOutput("inc_carry", {15'b0, carry}, 16'h1);
        applyStimulus(1'b1, 4'd9, 16'h0);
        checkOutput("dec",       aout, 16'hFFFF);
        checkOutput("dec_carry", {15'b0, carry}, 16'h1);
        applyStimulus(1'b1, 4'd9, 16'h0);
        checkOutput("dec_nb_carry", {15'b0, carry}, 16'h0);
        applyStimulus(1'b1, 4'd6, 16'h0);
        checkOutput("shr",       aout, 16'h7FFF);
        checkOutput("shr_carry", {15'b0, carry}, 16'h0);
        applyStimulus(1'b1, 4'd6, 16'h0);
        checkOutput("shr2",       aout, 16'h3FFF);
        checkOutput("shr2_carry", {15'b0, carry}, 16'h1);
        applyStimulus(1'b1, 4'd12, 16'h0);
        checkOutput("clr",       aout, 16'h0000);
        checkOutput("clr_carry", {15'b0, carry}, 16'h1);

        // Stack fill and overflow
        applyStimulus(1'b1, 4'd1, 16'h1111);
        applyStimulus(1'b1, 4'd10, 16'h0);
        applyStimulus(1'b1, 4'd1, 16'h2222);
        applyStimulus(1'b1, 4'd10, 16'h0);
        applyStimulus(1'b1, 4'd1, 16'h3333);
        applyStimulus(1'b1, 4'd10, 16'h0);
        checkOutput("not_full_3", {15'b0, stack_full}, 16'h0);
        applyStimulus(1'b1, 4'd1, 16'h4444);
        applyStimulus(1'b1, 4'd10, 16'h0);
        checkOutput("push_keeps_aout", aout, 16'h4444);
        checkOutput("full",  {15'b0, stack_full}, 16'h1);
        checkOutput("ovf_0", {15'b0, err_ovf}, 16'h0);
        applyStimulus(1'b1, 4'd10, 16'h0);
        checkOutput("ovf_1",     {15'b0, err_ovf}, 16'h1);
        checkOutput("ovf_full",  {15'b0, stack_full}, 16'h1);

        // Drain in LIFO order
        applyStimulus(1'b1, 4'd12, 16'h0);
        applyStimulus(1'b1, 4'd11, 16'h0);
        checkOutput("pop1", aout, 16'h4444);
        checkOutput("pop1_full", {15'b0, stack_full}, 16'h0);
        applyStimulus(1'b1, 4'd11, 16'h0);
        checkOutput("pop2", aout, 16'h3333);
        applyStimulus(1'b1, 4'd11, 16'h0);
        checkOutput("pop3", aout, 16'h2222);
        applyStimulus(1'b1, 4'd11, 16'h0);
        checkOutput("pop4",  aout, 16'h1111);
        checkOutput("empty", {15'b0, stack_empty}, 16'h1);

        // Underflow and sticky errors
        applyStimulus(1'b1, 4'd11, 16'h0);
        checkOutput("unf_aout", aout, 16'h1111);
        checkOutput("unf_1",    {15'b0, err_unf}, 16'h1);
        checkOutput("unf_ovf",  {15'b0, err_ovf}, 16'h1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 4'd0, 16'h0);
        checkOutput("unf_sticky", {14'b0, err_ovf, err_unf}, 16'h3);
        applyStimulus(1'b1, 4'd13, 16'h0);
        checkOutput("clr_err", {14'b0, err_ovf, err_unf}, 16'h0);

        // Push then pop on consecutive cycles
        applyStimulus(1'b1, 4'd1, 16'h5A5A);
        applyStimulus(1'b1, 4'd10, 16'h0);
        applyStimulus(1'b1, 4'd12, 16'h0);
        applyStimulus(1'b1, 4'd10, 16'h0);
        applyStimulus(1'b1, 4'd11, 16'h0);
        checkOutput("b2b_pop", aout, 16'h0000);
        applyStimulus(1'b1, 4'd11, 16'h0);
        checkOutput("b2b_pop2",  aout, 16'h5A5A);
        checkOutput("b2b_empty", {15'b0, stack_empty}, 16'h1);

        // Idle and reserved codes
        applyStimulus(1'b0, 4'd1, 16'hFFFF);
        checkOutput("idle_hold", aout, 16'h5A5A);
        applyStimulus(1'b1, 4'd14, 16'hFFFF);
        checkOutput("rsvd14_aout", aout, 16'h5A5A);
        checkOutput("rsvd14_errs", {14'b0, err_ovf, err_unf}, 16'h0);
        applyStimulus(1'b1, 4'd15, 16'h0000);
        checkOutput("rsvd15_aout",  aout, 16'h5A5A);
        checkOutput("carry_kept",   {15'b0, carry}, 16'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/acc_stack_unit.md
Name: acc_stack_unit

Overview:
Parametrised accumulator for the SAP datapath. It extends the plain load and lower-byte-load accumulator with several load modes, shift/increment operations, a carry flag and a small LIFO save/restore stack for the accumulator value. It sits between the system bus and the ALU A-input. It is driven by the control sequencer through a single op/op_valid command interface.

Parameters:
WIDTH, 16, accumulator/bus width; must be even and >= 8; HALF = WIDTH/2
DEPTH, 4, save-stack entries; must be >= 1; pointer width clog2(DEPTH+1)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, synchronous, active-high
op_valid  input  1  command strobe; op is ignored when 0
op  input  4  command code (see Behaviour)
bus  input  WIDTH  data from system bus
aout  output  WIDTH  accumulator value, registered
carry  output  1  carry/borrow flag, registered
zero  output  1  aout == 0, combinational from aout
neg  output  1  aout[WIDTH-1], combinational
stack_full  output  1  stack count == DEPTH, combinational from count
stack_empty  output  1  stack count == 0
err_ovf  output  1  sticky: PUSH attempted while full
err_unf  output  1  sticky: POP attempted while empty

Behaviour:
- All state updates on rising clk. Result is visible on aout/carry one cycle after the op_valid cycle. Zero-latency flags follow aout.
- Reset (rst=1 at edge): aout=0, carry=0, count=0, err_ovf=0, err_unf=0. Stack RAM contents are don't-care. rst overrides any concurrent op, including mid-sequence pushes.
- op_valid=0: all state holds.
- Op codes (op_valid=1):
  - 0 NOP: hold.
  - 1 LOAD: aout=bus.
  - 2 LOAD_LO: aout={HALF'b0, bus[HALF-1:0]}.
  - 3 LOAD_LO_SX: aout=sign-extend bus[HALF-1:0].
  - 4 LOAD_HI: aout={bus[HALF-1:0], aout[HALF-1:0]}. Lower half is preserved.
  - 5 SHL: carry=aout[WIDTH-1]; aout={aout[WIDTH-2:0],1'b0}.
  - 6 SHR (logical): carry=aout[0]; aout={1'b0,aout[WIDTH-1:1]}.
  - 7 ROL through carry: {carry,aout} rotated left by 1.
  - 8 INC: {carry,aout}=aout+1. Wraps all-ones to 0 with carry=1.
  - 9 DEC: aout=aout-1; carry=1 iff aout was 0 (borrow). Wraps to all-ones.
  - 10 PUSH: if count<DEPTH, stack[count]=aout and count+1; aout unchanged. If full, no change except err_ovf=1.
  - 11 POP: if count>0, aout=stack[count-1] and count-1. If empty, aout unchanged and err_unf=1.
  - 12 CLR: aout=0. Carry is unaffected.
  - 13 CLR_ERR: err_ovf=0, err_unf=0.
  - 14, 15: reserved; behave as NOP with no error.
- Carry changes only on ops 5-9. All other ops preserve it.
- Stack is pure LIFO. Count saturates at 0 and DEPTH; the pointer never wraps.
- Error flags stay set until CLR_ERR or rst. A failed PUSH/POP does not clear the other flag.
- Back-to-back PUSH then POP on consecutive cycles returns the pushed value.
- One op per cycle. No handshake back-pressure; every valid op completes in one cycle.

Test Plan:
- Reset/load: rst, then LOAD bus=0xA5C3 -> aout=0xA5C3, zero=0, neg=1. LOAD_LO bus=0x12F0 -> aout=0x00F0. LOAD_LO_SX bus=0x0080 -> aout=0xFF80.
- LOAD_HI: aout=0x00F0, LOAD_HI bus=0x3412 -> aout=0x12F0. rst asserted together with LOAD -> aout=0.
- Shift/arith: aout=0x8001, SHL -> aout=0x0002, carry=1. ROL -> aout=0x0005, carry=0. aout=0xFFFF, INC -> aout=0x0000, zero=1, carry=1. DEC -> aout=0xFFFF, carry=1.
- Stack (DEPTH=4): push 0x1111, 0x2222, 0x3333, 0x4444 -> stack_full=1. 5th PUSH -> err_ovf=1, count stays 4. Four POPs -> aout=0x4444, 0x3333, 0x2222, 0x1111, then stack_empty=1.
- Underflow/sticky: POP while empty -> aout unchanged, err_unf=1. NOP x3 -> flag still 1. CLR_ERR -> both flags 0.
- Idle/reserved: op_valid=0 with op=LOAD -> no change. op=14 valid -> no change, no error flags.
